// File: rtl/inst_encoder_if.sv
// Request/response bundle for inst_encoder: decoded-field request in, encoded RV32I word out.
// The slave modport is the encoder's view; the master modport is the issuing/consuming side.
interface inst_encoder_if #(
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_fmt;
  logic [6:0]       in_opcode;
  logic [2:0]       in_func3;
  logic [6:0]       in_func7;
  logic [4:0]       in_rd;
  logic [4:0]       in_rs1;
  logic [4:0]       in_rs2;
  logic [31:0]      in_imm;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_inst;
  logic [CNT_W-1:0] count;
  logic             err;

  modport slave (
    input  in_valid, in_fmt, in_opcode, in_func3, in_func7,
    input  in_rd, in_rs1, in_rs2, in_imm, out_ready,
    output in_ready, out_valid, out_inst, count, err
  );

  modport master (
    output in_valid, in_fmt, in_opcode, in_func3, in_func7,
    output in_rd, in_rs1, in_rs2, in_imm, out_ready,
    input  in_ready, out_valid, out_inst, count, err
  );
endinterface

// File: rtl/inst_encoder.sv
// RV32I instruction encoder feeding a DEPTH-entry FIFO (valid/ready on both sides).
// Optional immediate-range checking is enabled by defining INST_ENC_CHECK_EN.
module inst_encoder #(
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          resetn,
  inst_encoder_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [31:0]      NOP  = 32'h0000_0013;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  function automatic logic [31:0] encode(
    input logic [2:0]  fmt,
    input logic [6:0]  op,
    input logic [2:0]  f3,
    input logic [6:0]  f7,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [31:0] imm
  );
    logic [31:0] w;
    w = NOP;
    case (fmt)
      3'b000: w = {imm[11:0], rs1, f3, rd, op};
      3'b001: w = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
      3'b010: w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
      3'b011: w = {imm[31:12], rd, op};
      3'b100: w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
      3'b101: w = {f7, rs2, rs1, f3, rd, op};
      default: w = NOP;
    endcase
    return w;
  endfunction

`ifdef INST_ENC_CHECK_EN
  // Sign-extension checks: the bits above each field must replicate its top bit.
  function automatic logic imm_bad(input logic [2:0] fmt, input logic [31:0] imm);
    logic b;
    b = 1'b0;
    case (fmt)
      3'b000, 3'b001: b = !((&imm[31:11]) || !(|imm[31:11]));
      3'b010:         b = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
      3'b011:         b = |imm[11:0];
      3'b100:         b = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
      3'b101:         b = 1'b0;
      default:        b = 1'b1;
    endcase
    return b;
  endfunction
`endif

  logic [31:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic [31:0]      inst_p0;
  logic             vld_p0;
  logic             pop;

  assign bus.in_ready  = (count_q != FULL);
  assign bus.out_valid = (count_q != '0);
  assign bus.out_inst  = (count_q != '0) ? mem[rd_ptr] : 32'h0;
  assign bus.count     = count_q;

  assign vld_p0 = bus.in_valid && (count_q != FULL);
  assign pop    = bus.out_ready && (count_q != '0);

  // Stage p0: combinational encode of the presented request
  always_comb begin
    inst_p0 = encode(bus.in_fmt, bus.in_opcode, bus.in_func3, bus.in_func7,
                     bus.in_rd, bus.in_rs1, bus.in_rs2, bus.in_imm);
`ifdef INST_ENC_CHECK_EN
    if (imm_bad(bus.in_fmt, bus.in_imm)) inst_p0 = NOP;
`endif
  end

  // Stage p1: FIFO storage (data only, never reset)
  always_ff @(posedge clk) begin
    if (vld_p0) mem[wr_ptr] <= inst_p0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (vld_p0) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)    rd_ptr <= rd_ptr + PTR_W'(1);
      case ({vld_p0, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef INST_ENC_CHECK_EN
  logic err_p1;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) err_p1 <= 1'b0;
    else         err_p1 <= vld_p0 && imm_bad(bus.in_fmt, bus.in_imm);
  end

  assign bus.err = err_p1;
`else
  assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_inst_encoder.sv
// Bench for inst_encoder: directed vector table, FIFO corner sequences and a random scoreboard run.
module tb_inst_encoder;
  localparam int DEPTH = 4;
`ifdef INST_ENC_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  inst_encoder_if #(.DEPTH(DEPTH)) bus ();
  inst_encoder #(.DEPTH(DEPTH)) dut (.clk(clk), .resetn(resetn), .bus(bus.slave));

  int tests = 0;
  int fails = 0;
  logic [31:0] q[$];

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] exp;
    logic        exp_err;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Move a w-bit field starting at bit src of v to bit position dst.
  function automatic bit [31:0] mv(bit [31:0] v, int src, int w, int dst);
    return ((v >> src) & ((32'h1 << w) - 32'h1)) << dst;
  endfunction

  function automatic bit ref_bad(bit [2:0] fmt, bit [31:0] imm);
    longint s;
    s = longint'($signed(imm));
    case (fmt)
      3'd0, 3'd1: return !(s >= -2048 && s <= 2047);
      3'd2:       return !(s >= -4096 && s <= 4095) || (imm % 2 != 0);
      3'd3:       return (imm % 4096) != 0;
      3'd4:       return !(s >= -(longint'(1) << 20) && s < (longint'(1) << 20)) || (imm % 2 != 0);
      3'd5:       return 1'b0;
      default:    return 1'b1;
    endcase
  endfunction

  function automatic bit [31:0] ref_enc(bit [2:0] fmt, bit [6:0] op, bit [2:0] f3, bit [6:0] f7,
                                        bit [4:0] rd, bit [4:0] rs1, bit [4:0] rs2, bit [31:0] imm);
    bit [31:0] r, rr1, rr2, ff3, rdd;
    if (CHECK_EN && ref_bad(fmt, imm)) return NOP;
    rdd = mv(32'(rd), 0, 5, 7);
    ff3 = mv(32'(f3), 0, 3, 12);
    rr1 = mv(32'(rs1), 0, 5, 15);
    rr2 = mv(32'(rs2), 0, 5, 20);
    case (fmt)
      3'd0: r = mv(imm, 0, 12, 20) | rr1 | ff3 | rdd;
      3'd1: r = mv(imm, 5, 7, 25) | rr2 | rr1 | ff3 | mv(imm, 0, 5, 7);
      3'd2: r = mv(imm, 12, 1, 31) | mv(imm, 5, 6, 25) | rr2 | rr1 | ff3 | mv(imm, 1, 4, 8) | mv(imm, 11, 1, 7);
      3'd3: r = mv(imm, 12, 20, 12) | rdd;
      3'd4: r = mv(imm, 20, 1, 31) | mv(imm, 1, 10, 21) | mv(imm, 11, 1, 20) | mv(imm, 12, 8, 12) | rdd;
      3'd5: r = mv(32'(f7), 0, 7, 25) | rr2 | rr1 | ff3 | rdd;
      default: return NOP;
    endcase
    return r | 32'(op);
  endfunction

  task automatic set_req(input vec_t v);
    bus.in_fmt = v.fmt; bus.in_opcode = v.op; bus.in_func3 = v.f3; bus.in_func7 = v.f7;
    bus.in_rd = v.rd; bus.in_rs1 = v.rs1; bus.in_rs2 = v.rs2; bus.in_imm = v.imm;
  endtask

  task automatic rand_req();
    int sel;
    bus.in_fmt    = 3'($urandom_range(0, 7));
    bus.in_opcode = 7'($urandom);
    bus.in_func3  = 3'($urandom);
    bus.in_func7  = 7'($urandom);
    bus.in_rd     = 5'($urandom);
    bus.in_rs1    = 5'($urandom);
    bus.in_rs2    = 5'($urandom);
    sel = int'($urandom_range(0, 2));
    if (sel == 0)      bus.in_imm = $urandom;
    else if (sel == 1) bus.in_imm = 32'(int'($urandom_range(0, 8191)) - 4096) & 32'hFFFF_FFFE;
    else               bus.in_imm = $urandom & 32'hFFFF_F000;
  endtask

  // One clock of the scoreboard: check outputs before the edge, advance the model, check after.
  task automatic step();
    bit push, pop, bad;
    bit [31:0] e;
    chk("in_ready", bus.in_ready, 32'(q.size() != DEPTH));
    chk("out_valid", bus.out_valid, 32'(q.size() != 0));
    chk("out_inst", bus.out_inst, (q.size() != 0) ? q[0] : 32'h0);
    push = bus.in_valid && (q.size() < DEPTH);
    pop  = bus.out_ready && (q.size() > 0);
    e    = ref_enc(bus.in_fmt, bus.in_opcode, bus.in_func3, bus.in_func7,
                   bus.in_rd, bus.in_rs1, bus.in_rs2, bus.in_imm);
    bad  = ref_bad(bus.in_fmt, bus.in_imm);
    @(posedge clk); #1;
    if (pop)  void'(q.pop_front());
    if (push) q.push_back(e);
    chk("count", 32'(bus.count), 32'(q.size()));
    chk("err", bus.err, 32'(push && CHECK_EN && bad));
  endtask

  initial begin
    vec_t b3;
    vecs[0] = '{3'd0, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5,          32'h0050_0093, 1'b0};
    vecs[1] = '{3'd1, 7'h23, 3'd2, 7'h00, 5'd0, 5'd1, 5'd2, 32'd8,          32'h0020_A423, 1'b0};
    vecs[2] = '{3'd2, 7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC,  32'hFE20_8EE3, 1'b0};
    vecs[3] = '{3'd4, 7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd8,          32'h0080_00EF, 1'b0};
    vecs[4] = '{3'd5, 7'h33, 3'd0, 7'h20, 5'd3, 5'd1, 5'd2, 32'd0,          32'h4020_81B3, 1'b0};
    vecs[5] = '{3'd3, 7'h37, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h1234_5000,  32'h1234_52B7, 1'b0};
    vecs[6] = '{3'd6, 7'h33, 3'd1, 7'h7F, 5'd3, 5'd1, 5'd2, 32'h0000_0001,  NOP,           CHECK_EN};

    resetn = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    set_req(vecs[0]);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", bus.in_ready, 32'd1);
    chk("rst_out_valid", bus.out_valid, 32'd0);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_out_inst", bus.out_inst, 32'd0);
    chk("rst_err", bus.err, 32'd0);
    resetn = 1'b1;
    @(posedge clk); #1;

    // Directed vectors: one push, then one pop.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      set_req(vecs[i]);
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      chk($sformatf("vec%0d_valid", i), bus.out_valid, 32'd1);
      chk($sformatf("vec%0d_inst", i), bus.out_inst, vecs[i].exp);
      chk($sformatf("vec%0d_count", i), 32'(bus.count), 32'd1);
      chk($sformatf("vec%0d_err", i), bus.err, 32'(vecs[i].exp_err));
      @(posedge clk); #1;
      chk($sformatf("vec%0d_drain", i), 32'(bus.count), 32'd0);
      chk($sformatf("vec%0d_empty_inst", i), bus.out_inst, 32'd0);
    end

    // B-format with an odd immediate.
    b3 = '{3'd2, 7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'd3, 32'h0, 1'b0};
    set_req(b3);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("b_odd_inst", bus.out_inst, CHECK_EN ? NOP : 32'h0020_8163);
    chk("b_odd_err", bus.err, 32'(CHECK_EN));
    @(posedge clk); #1;
    chk("b_odd_err_pulse", bus.err, 32'd0);
    chk("b_odd_drain", 32'(bus.count), 32'd0);

    // Fill to full with the consumer stalled, then overflow attempt.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rand_req();
      step();
    end
    chk("full_in_ready", bus.in_ready, 32'd0);
    chk("full_count", 32'(bus.count), 32'(DEPTH));

    // Release consumer while still pushing, then drain in order.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rand_req();
      step();
    end
    bus.in_valid = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) step();
    chk("drained_valid", bus.out_valid, 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      rand_req();
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    // Reset mid-stream with three entries queued.
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      bus.out_ready = 1'b1;
      step();
    end
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_req();
      step();
    end
    bus.in_valid = 1'b0;
    chk("pre_rst_count", 32'(bus.count), 32'd3);
    #3;
    resetn = 1'b0;
    #1;
    chk("mid_rst_out_valid", bus.out_valid, 32'd0);
    chk("mid_rst_count", 32'(bus.count), 32'd0);
    chk("mid_rst_in_ready", bus.in_ready, 32'd1);
    chk("mid_rst_out_inst", bus.out_inst, 32'd0);
    q.delete();
    @(posedge clk); #1;
    resetn = 1'b1;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rand_req();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
- Builds RV32I instruction words from decoded fields (format, opcode, func3/func7, register indices, immediate) and queues them for a downstream consumer.
- Performs the inverse of immediate extraction: scatters the immediate into the I/S/B/U/J bit positions.
- Used in the SIM/AUX benches as the instruction-issuing end of the ALU/immediate-decode path.
- Valid/ready in, FIFO buffer, valid/ready out.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- resetn  input  1  asynchronous active-low reset.
- in_valid  input  1  request present.
- in_ready  output  1  request accepted when in_valid & in_ready at a clk edge.
- in_fmt  input  3  000 I, 001 S, 010 B, 011 U, 100 J, 101 R, 11x illegal.
- in_opcode  input  7  placed in inst[6:0].
- in_func3  input  3  placed in inst[14:12] (I/S/B/R).
- in_func7  input  7  placed in inst[31:25] (R only).
- in_rd  input  5  placed in inst[11:7] (I/U/J/R).
- in_rs1  input  5  placed in inst[19:15] (I/S/B/R).
- in_rs2  input  5  placed in inst[24:20] (S/B/R).
- in_imm  input  32  byte-offset / full immediate value.
- out_valid  output  1  head entry valid.
- out_ready  input  1  consumer takes head when out_valid & out_ready at a clk edge.
- out_inst  output  32  head entry; 0 when empty.
- count  output  $clog2(DEPTH)+1  occupancy.
- err  output  1  encode-error pulse; see Optional Feature.

Behaviour:
- Reset (async assert, sync release): read/write pointers 0, count 0, out_valid 0, err 0, in_ready 1.
- Encoding is combinational from the inputs; the result is written into the FIFO on accept.
  - I: {imm[11:0], rs1, f3, rd, op}.
  - S: {imm[11:5], rs2, rs1, f3, imm[4:0], op}.
  - B: {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op}.
  - U: {imm[31:12], rd, op}.
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}.
  - R: {f7, rs2, rs1, f3, rd, op}.
  - Illegal fmt: canonical NOP 32'h00000013.
  - Unused field inputs are ignored.
- in_ready = (count != DEPTH); registered-state-derived, never depends on out_ready (no pass-through when full).
- out_valid = (count != 0); out_inst = mem[rd_ptr].
- Latency: request accepted at edge k appears on out_inst/out_valid after edge k (1 cycle).
- Handshake:
  - Push only: count+1.
  - Pop only: count-1.
  - Push and pop in same edge (count 1..DEPTH-1): count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH.
- Strict FIFO order.
- Held inputs with in_ready low are not consumed.
- Full: push ignored, no state change, in_ready stays 0 until a pop.
- Empty: pop impossible; out_ready ignored.
- resetn low mid-stream: all queued entries discarded immediately, outputs return to reset values.

Optional Feature:
- Macro: INST_ENC_CHECK_EN.
- Defined: each accepted request is checked. The request is an error if any of the following hold:
  - I/S: imm[31:11] not all equal.
  - B: imm[31:12] not all equal, or imm[0] = 1.
  - J: imm[31:20] not all equal, or imm[0] = 1.
  - U: imm[11:0] != 0.
  - fmt 11x.
- On error: the entry is still queued but encoded as NOP 32'h00000013, and err pulses high for exactly one cycle after the accepting edge.
- Not defined: no checks, err tied 0, immediate bits outside each format's field are silently dropped, illegal fmt still yields NOP.

Test Plan:
- After reset, fmt I, op 0x13, f3 0, rd 1, rs1 0, imm 5, out_ready 1 -> next cycle out_valid 1, out_inst 0x00500093, count 1.
- fmt S, op 0x23, f3 2, rs1 1, rs2 2, imm 8 -> 0x0020A423.
- fmt B, op 0x63, f3 0, rs1 1, rs2 2, imm 0xFFFFFFFC -> 0xFE208EE3.
- Ordering and J encoding: fmt J, op 0x6F, rd 1, imm 8 -> 0x008000EF, then fmt R, op 0x33, f7 0x20, f3 0, rd 3, rs1 1, rs2 2 -> 0x402081B3.
- FIFO full/empty with DEPTH=4, out_ready 0:
  - 4 pushes -> count 4, in_ready 0; 5th request ignored.
  - Set out_ready 1 with in_valid 1 -> simultaneous push/pop holds count; drains in order, out_valid 0 at count 0.
- Reset mid-stream with count 3: assert resetn low -> out_valid 0, count 0, in_ready 1 without a clock edge.
- With INST_ENC_CHECK_EN: fmt B, imm 3 -> out_inst 0x00000013, err high one cycle.
- Without INST_ENC_CHECK_EN: same request -> B encoding with imm[0] dropped, err 0.
